// File: rtl/pkt_stream_pkg.sv
// rtl/pkt_stream_pkg.sv - shared types and helpers for the packet streamer
package pkt_stream_pkg;

    localparam int BYTES_PER_BEAT = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    // Unused byte lanes in the final beat for a given length modulo 4.
    function automatic logic [1:0] empty_of(input logic [1:0] len_lsb);
        return 2'(3'(BYTES_PER_BEAT) - {1'b0, len_lsb});
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// rtl/beat_fifo.sv - synchronous beat FIFO with occupancy count
module beat_fifo
    import pkt_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  beat_t                  push_beat,
    input  logic                   pop,
    output beat_t                  head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    beat_t          store [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_beat;
        end
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/packet_streamer.sv
// rtl/packet_streamer.sv - memory-to-stream frame player with credit-limited prefetch
module packet_streamer
    import pkt_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BYTES  = 1518
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] byte_len,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        ready,
    output logic [31:0] data_out,
    output logic        sop,
    output logic        eop,
    output logic [1:0]  empty,
    output logic [5:0]  error,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t         state;
    state_t         state_nxt;
    logic [31:0]    base_q;
    logic [15:0]    words_q;
    logic [15:0]    issued_q;
    logic [1:0]     empty_last_q;
    logic           err_q;
    logic           pend_q;
    logic           pend_sop_q;
    logic           pend_eop_q;
    logic [1:0]     pend_empty_q;
    logic [CW-1:0]  fifo_count;
    beat_t          head;
    beat_t          push_beat;
    logic           pop;
    logic           len_bad;
    logic           has_credit;
    logic           rd_last;

    assign len_bad    = (byte_len == 16'd0) || (32'(byte_len) > 32'(MAX_BYTES));
    // A read is only issued if its data is guaranteed a FIFO slot on arrival.
    assign has_credit = (32'(fifo_count) + 32'(pend_q)) < 32'(FIFO_DEPTH);
    assign rd_last    = (issued_q == words_q - 16'd1);

    assign mem_read  = (state == FETCH) && (issued_q < words_q) && has_credit;
    assign mem_addr  = mem_read ? (base_q + {14'd0, issued_q, 2'b00}) : 32'd0;

    assign push_beat = '{data: mem_rdata, sop: pend_sop_q, eop: pend_eop_q, empty: pend_empty_q};
    assign valid     = (fifo_count != '0);
    assign pop       = valid && ready;

    assign data_out  = valid ? head.data  : 32'd0;
    assign sop       = valid ? head.sop   : 1'b0;
    assign eop       = valid ? head.eop   : 1'b0;
    assign empty     = valid ? head.empty : 2'd0;
    assign error     = 6'd0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign len_err   = done && err_q;

    beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (pend_q),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: fetch until all words issued, drain until eop leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = len_bad ? DONE : FETCH;
            FETCH: if (issued_q == words_q) state_nxt = DRAIN;
            DRAIN: if (pop && head.eop) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame parameters, read counter and tags for the read in flight.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            base_q       <= '0;
            words_q      <= '0;
            issued_q     <= '0;
            empty_last_q <= '0;
            err_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_sop_q   <= 1'b0;
            pend_eop_q   <= 1'b0;
            pend_empty_q <= '0;
        end else begin
            pend_q <= mem_read;
            if (state == IDLE && start) begin
                base_q       <= base_addr & ~32'd3;
                words_q      <= (byte_len + 16'd3) >> 2;
                empty_last_q <= empty_of(byte_len[1:0]);
                err_q        <= len_bad;
                issued_q     <= '0;
            end
            if (mem_read) begin
                issued_q     <= issued_q + 16'd1;
                pend_sop_q   <= (issued_q == 16'd0);
                pend_eop_q   <= rd_last;
                pend_empty_q <= rd_last ? empty_last_q : 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_packet_streamer.sv
// tb/tb_packet_streamer.sv - directed self-checking bench for packet_streamer
module tb_packet_streamer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] byte_len;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_rdata = 32'd0;
    logic        ready;
    logic [31:0] data_out;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [5:0]  error;
    logic        valid;
    logic        busy;
    logic        done;
    logic        len_err;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic done_err = 1'b0;

    logic [35:0] beat_q [$];
    int          beat_cyc_q [$];
    logic [31:0] addr_q [$];
    logic        prev_stall = 1'b0;
    logic [35:0] prev_beat  = '0;

    packet_streamer dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .base_addr (base_addr),
        .byte_len  (byte_len),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .ready     (ready),
        .data_out  (data_out),
        .sop       (sop),
        .eop       (eop),
        .empty     (empty),
        .error     (error),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: word at byte address a holds A000_0000 + a/4, one cycle latency.
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= 32'hA000_0000 + (mem_addr >> 2);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: transfers, reads, done pulses, stall stability.
    always @(negedge clk) begin
        if (prev_stall) check_eq("stall_hold", {27'd0, valid, sop, eop, empty, data_out}, {27'd0, 1'b1, prev_beat});
        prev_stall = n_rst && valid && !ready;
        prev_beat  = {sop, eop, empty, data_out};
        if (valid && ready) begin
            beat_q.push_back({data_out, sop, eop, empty});
            beat_cyc_q.push_back(cyc);
        end
        if (mem_read) addr_q.push_back(mem_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = len_err;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] len, output int s);
        beat_q.delete();
        beat_cyc_q.delete();
        addr_q.delete();
        start     = 1'b1;
        base_addr = base;
        byte_len  = len;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            if (toggle) ready = ~ready;
            tick();
        end
        check_eq("done_seen", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic verify_frame(input logic [31:0] base, input int len);
        int words = (len + 3) / 4;
        logic [1:0] el = 2'((4 - (len % 4)) % 4);
        logic [35:0] exp;
        check_eq("beat_count", 64'(beat_q.size()), 64'(words));
        for (int i = 0; i < words && i < beat_q.size(); i++) begin
            exp = {32'hA000_0000 + (base >> 2) + 32'(i), i == 0, i == words - 1,
                   (i == words - 1) ? el : 2'd0};
            check_eq($sformatf("beat%0d", i), 64'(beat_q[i]), 64'(exp));
        end
        check_eq("addr_count", 64'(addr_q.size()), 64'(words));
        for (int i = 0; i < words && i < addr_q.size(); i++)
            check_eq($sformatf("addr%0d", i), 64'(addr_q[i]), 64'(base + 32'(4 * i)));
        if (beat_cyc_q.size() > 0)
            check_eq("done_after_eop", 64'(done_cyc), 64'(beat_cyc_q[beat_cyc_q.size() - 1] + 1));
        check_eq("len_err_clear", 64'(done_err), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_addr_data"}, {mem_addr, data_out}, 64'd0);
        check_eq({tag, "_ctrl"}, 64'({mem_read, sop, eop, empty, error, valid, busy, done, len_err}), 64'd0);
    endtask

    initial begin
        int s;
        int e;
        n_rst = 1'b0; start = 1'b0; base_addr = '0; byte_len = '0; ready = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        n_rst = 1'b1;
        tick();

        // 64 bytes, free-running sink.
        do_start(32'h0, 16'd64, s);
        wait_done(60, 1'b0);
        check_eq("first_valid_cyc", 64'(beat_cyc_q.size() > 0 ? beat_cyc_q[0] : -1), 64'(s + 3));
        check_eq("last_beat_cyc", 64'(beat_cyc_q.size() == 16 ? beat_cyc_q[15] : -1), 64'(s + 18));
        verify_frame(32'h0, 64);

        // 61 bytes, unaligned base whose low bits must be ignored (back-to-back start).
        do_start(32'h203, 16'd61, s);
        wait_done(60, 1'b0);
        verify_frame(32'h200, 61);

        // Single-byte frame.
        do_start(32'h80, 16'd1, s);
        wait_done(20, 1'b0);
        verify_frame(32'h80, 1);

        // Sink stalled: prefetch stops at the FIFO depth, beat 0 held.
        ready = 1'b0;
        do_start(32'h400, 16'd64, s);
        repeat (20) tick();
        check_eq("stall_reads", 64'(addr_q.size()), 64'd4);
        check_eq("stall_no_read", 64'(mem_read), 64'd0);
        check_eq("stall_head", {30'd0, valid, sop, data_out}, {30'd0, 1'b1, 1'b1, 32'hA000_0100});
        ready = 1'b1;
        wait_done(80, 1'b0);
        verify_frame(32'h400, 64);

        // Alternating ready over 60 bytes.
        do_start(32'h40, 16'd60, s);
        wait_done(100, 1'b1);
        ready = 1'b1;
        verify_frame(32'h40, 60);

        // Illegal lengths: no reads, no beats, done+len_err at k+1.
        do_start(32'h0, 16'd0, s);
        wait_done(5, 1'b0);
        check_eq("len0_done_cyc", 64'(done_cyc), 64'(s + 1));
        check_eq("len0_err", 64'(done_err), 64'd1);
        check_eq("len0_quiet", 64'(addr_q.size() + beat_q.size()), 64'd0);
        do_start(32'h0, 16'd1519, s);
        wait_done(5, 1'b0);
        check_eq("len1519_done_cyc", 64'(done_cyc), 64'(s + 1));
        check_eq("len1519_err", 64'(done_err), 64'd1);
        check_eq("len1519_quiet", 64'(addr_q.size() + beat_q.size()), 64'd0);
        tick();
        do_start(32'h0, 16'd1518, s);
        wait_done(500, 1'b0);
        verify_frame(32'h0, 1518);

        // Start while busy is ignored.
        do_start(32'h0, 16'd8, s);
        start = 1'b1; byte_len = 16'd64;
        tick();
        start = 1'b0;
        wait_done(30, 1'b0);
        repeat (6) tick();
        verify_frame(32'h0, 8);
        check_eq("busy_start_ignored", 64'({busy, 8'(done_cnt)}), 64'({1'b0, 8'(done_cnt)}));

        // Reset during beat 5 aborts; a new start replays from sop.
        do_start(32'h0, 16'd64, s);
        for (int i = 0; i < 40 && beat_q.size() < 5; i++) tick();
        n_rst = 1'b0;
        tick();
        check_idle_outputs("midrst");
        e = 0;
        foreach (beat_q[i]) e += int'(beat_q[i][2]);
        check_eq("abort_no_eop", 64'(e), 64'd0);
        n_rst = 1'b1;
        tick();
        do_start(32'h0, 16'd64, s);
        wait_done(60, 1'b0);
        verify_frame(32'h0, 64);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/packet_streamer.md
Name: packet_streamer

Overview:
- Avalon-ST packet source: the transmit end of the stream interface that ethernetsniffer consumes.
- Fetches a stored Ethernet frame from word-addressed on-chip memory and emits it as data/sop/eop/empty/error/valid beats, honouring sink ready.
- Used as the on-chip frame player feeding the sniffer in system builds and benches.
- Decouples 1-cycle memory read latency from sink backpressure with a small credit-controlled FIFO.

Parameters:
FIFO_DEPTH, 4, beat FIFO entries (power of 2, >=2)
MAX_BYTES, 1518, largest accepted byte_len; larger raises len_err

Ports:
clk  input  1  system clock
n_rst  input  1  reset; synchronous and active-low
start  input  1  one-cycle request to send a frame; sampled only in IDLE
base_addr  input  32  byte address of the frame's first word (bits[1:0] ignored)
byte_len  input  16  frame length in bytes
mem_addr  output  32  memory read address, byte address, steps by 4
mem_read  output  1  read strobe; mem_rdata is valid exactly one cycle later
mem_rdata  input  32  memory read data
ready  input  1  sink ready (ready latency 0)
data_out  output  32  beat data; first frame byte in [31:24]
sop  output  1  first beat of frame
eop  output  1  last beat of frame
empty  output  2  unused bytes in the eop beat; 0 on all other beats
error  output  6  always 0 on streamed beats
valid  output  1  beat qualifier
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at frame completion
len_err  output  1  one-cycle pulse, with done, when byte_len is 0 or > MAX_BYTES

Behaviour:
- Reset (n_rst low at a clk edge): FSM to IDLE; FIFO, counters and outstanding flag cleared. All outputs 0, including mem_addr and data_out. Reset mid-frame aborts the frame with no eop and does not reissue it.
- Beat count: words = ceil(byte_len/4), computed as (byte_len+3)>>2 at 16 bits. Last-beat empty = (4 - byte_len[1:0]) & 3.
- States:
  - IDLE: start accepted at edge k. Latch base, words and empty_last. If the length is illegal, go to DONE. Otherwise go to FETCH.
  - FETCH: mem_read=1 when issued < words and (fifo_count + outstanding) < FIFO_DEPTH. mem_addr = base + 4*issued. First read occurs in cycle k+1. Go to DRAIN when issued == words.
  - DRAIN: no reads. Go to DONE on the cycle the eop beat transfers.
  - DONE: done=1 for one cycle, len_err=1 if the length was illegal, busy=0 next cycle. Return to IDLE.
- FIFO write: the mem_read issued in cycle n writes mem_rdata in cycle n+1. Credit accounting guarantees the FIFO never overflows.
- valid = FIFO not empty, so the first valid is in cycle k+3.
- Beat transfer occurs when valid && ready.
- While valid && !ready, data_out/sop/eop/empty stay stable.
- valid never drops without a transfer.
- sop=1 on the beat with sent==0. eop=1 on the beat with sent==words-1.
- Simultaneous FIFO push and pop in the same cycle leaves the count unchanged.
- Back-to-back frames: the next start is accepted in the cycle after done. This gives at least 3 idle cycles between eop and the next sop.
- busy=1 in FETCH, DRAIN and DONE. start is ignored while busy.
- Counters (issued, sent): 16-bit. No wrap is possible given MAX_BYTES.

Decomposition:
- Package pkt_stream_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - BYTES_PER_BEAT=4;
  - the function empty_of(len[1:0]).
- Sub-module beat_fifo (synchronous FIFO, data+sop+eop+empty, count output). Instantiated once.
- FSM, credit logic and address generation live in packet_streamer.

Test Plan:
- byte_len=64, ready=1, memory word i = 32'hA000_0000+i -> 16 beats on consecutive cycles from k+3, sop on beat 0, eop on beat 15, empty=0, done at eop+1.
- byte_len=61 -> 16 beats, eop beat has empty=3. byte_len=1 -> single beat with sop=eop=1, empty=3.
- byte_len=64, ready held 0 -> exactly 4 mem_reads (FIFO_DEPTH), then mem_read=0. Beat 0 held stable. After ready rises, beats resume in order with no loss or duplication.
- ready toggles 1,0,1,0 over 60 bytes -> 15 beats delivered in order. mem_addr sequence base, base+4, ... base+56.
- byte_len=0 and byte_len=1519 -> no mem_read, no valid. done and len_err pulse together in cycle k+1.
- start while busy -> ignored. n_rst low during beat 5 -> all outputs 0 next cycle. A new start then replays from sop.
